// File: rtl/vend_dispense_ctrl.sv
// Vend dispense controller: queues vend orders (change flag per order) and sequences
// the product dispenser and change hopper handshakes with a timeout-to-fault guard.
module vend_dispense_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       prod_in,
  input  logic       change_in,
  output logic       disp_req,
  input  logic       disp_done,
  output logic       hop_req,
  input  logic       hop_done,
  input  logic       fault_clr,
  output logic       busy,
  output logic       fault,
  output logic       overflow,
  output logic [2:0] q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0]    FULL_CNT   = 3'(DEPTH);

  typedef enum logic [1:0] {IDLE, DISP, HOP, FAULT} state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             chg_q, chg_d;
  logic             ovf_q, ovf_d;
  logic             pop, push, full;

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    timer_d  = timer_q;
    chg_d    = chg_q;

    full = (count_q == FULL_CNT);
    pop  = (state_q == IDLE) && (count_q != 3'd0);
    // A full queue still accepts an order when the head leaves on the same edge.
    push  = prod_in && (!full || pop);
    ovf_d = prod_in && full && !pop;

    if (push) begin
      mem_d[wr_ptr_q] = change_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) begin
          chg_d   = mem_q[rd_ptr_q];
          timer_d = '0;
          state_d = DISP;
        end
      end
      DISP: begin
        if (disp_done) begin
          state_d = chg_q ? HOP : IDLE;
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          state_d = FAULT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      HOP: begin
        if (hop_done) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          state_d = FAULT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      FAULT: begin
        // The in-flight order is simply dropped; the queue keeps filling meanwhile.
        if (fault_clr) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 3'd0;
      timer_q  <= '0;
      chg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      chg_q    <= chg_d;
      ovf_q    <= ovf_d;
    end
  end

  assign disp_req = (state_q == DISP);
  assign hop_req  = (state_q == HOP);
  assign fault    = (state_q == FAULT);
  assign busy     = (state_q != IDLE) || (count_q != 3'd0);
  assign overflow = ovf_q;
  assign q_count  = count_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl: inputs change 1 time unit after each rising
// edge, and outputs are sampled there, reflecting the state just latched.
module tb_vend_dispense_ctrl;

  logic       clk;
  logic       rst;
  logic       prod_in;
  logic       change_in;
  logic       disp_req;
  logic       disp_done;
  logic       hop_req;
  logic       hop_done;
  logic       fault_clr;
  logic       busy;
  logic       fault;
  logic       overflow;
  logic [2:0] q_count;

  int checks   = 0;
  int failures = 0;

  vend_dispense_ctrl #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .prod_in   (prod_in),
    .change_in (change_in),
    .disp_req  (disp_req),
    .disp_done (disp_done),
    .hop_req   (hop_req),
    .hop_done  (hop_done),
    .fault_clr (fault_clr),
    .busy      (busy),
    .fault     (fault),
    .overflow  (overflow),
    .q_count   (q_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // FSM is in DISP on entry; finishes the order and lets IDLE pop the next one.
  task automatic serve(input logic flag, input logic [2:0] exp_cnt);
    check("serve_disp_req", 32'(disp_req), 32'd1);
    disp_done = 1'b1;
    step();
    disp_done = 1'b0;
    check("serve_hop_req", 32'(hop_req), 32'(flag));
    if (flag) begin
      step();
      check("serve_hop_hold", 32'(hop_req), 32'd1);
      hop_done = 1'b1;
      step();
      hop_done = 1'b0;
      check("serve_hop_end", 32'(hop_req), 32'd0);
    end
    step();
    check("serve_q_count", 32'(q_count), 32'(exp_cnt));
    $display("serve flag=%0d q_count=%0d disp_req=%0d", flag, q_count, disp_req);
  endtask

  logic       pulse_flag [5];
  logic [2:0] pulse_cnt  [5];
  logic       pulse_ovf  [5];

  initial begin
    rst = 1'b1; prod_in = 1'b0; change_in = 1'b0;
    disp_done = 1'b0; hop_done = 1'b0; fault_clr = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_q_count", 32'(q_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_disp_req", 32'(disp_req), 32'd0);
    check("rst_hop_req", 32'(hop_req), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    $display("reset done");

    // change_in alone and stray done pulses in IDLE are ignored
    change_in = 1'b1; disp_done = 1'b1; hop_done = 1'b1; fault_clr = 1'b1;
    step();
    change_in = 1'b0; disp_done = 1'b0; hop_done = 1'b0; fault_clr = 1'b0;
    check("ignore_q_count", 32'(q_count), 32'd0);
    check("ignore_busy", 32'(busy), 32'd0);
    check("ignore_disp_req", 32'(disp_req), 32'd0);

    // single order, no change
    prod_in = 1'b1; change_in = 1'b0;
    step();
    prod_in = 1'b0;
    check("t1_e0_q_count", 32'(q_count), 32'd1);
    check("t1_e0_disp_req", 32'(disp_req), 32'd0);
    check("t1_e0_busy", 32'(busy), 32'd1);
    step();
    check("t1_e1_disp_req", 32'(disp_req), 32'd1);
    check("t1_e1_q_count", 32'(q_count), 32'd0);
    step();
    check("t1_e2_disp_req", 32'(disp_req), 32'd1);
    step();
    check("t1_e3_disp_req", 32'(disp_req), 32'd1);
    check("t1_e3_hop_req", 32'(hop_req), 32'd0);
    disp_done = 1'b1;
    step();
    disp_done = 1'b0;
    check("t1_end_disp_req", 32'(disp_req), 32'd0);
    check("t1_end_hop_req", 32'(hop_req), 32'd0);
    check("t1_end_busy", 32'(busy), 32'd0);
    $display("single order no change: busy=%0d", busy);

    // order with change
    prod_in = 1'b1; change_in = 1'b1;
    step();
    prod_in = 1'b0; change_in = 1'b0;
    step();
    check("t2_disp_req", 32'(disp_req), 32'd1);
    disp_done = 1'b1;
    step();
    disp_done = 1'b0;
    check("t2_hop_req", 32'(hop_req), 32'd1);
    check("t2_disp_off", 32'(disp_req), 32'd0);
    step();
    check("t2_hop_hold", 32'(hop_req), 32'd1);
    hop_done = 1'b1;
    step();
    hop_done = 1'b0;
    check("t2_end_hop_req", 32'(hop_req), 32'd0);
    check("t2_end_busy", 32'(busy), 32'd0);
    $display("order with change: busy=%0d", busy);

    // overflow: park order A (no change) in DISP, then five back-to-back pulses
    prod_in = 1'b1; change_in = 1'b0;
    step();
    prod_in = 1'b0;
    step();
    check("t3_disp_req", 32'(disp_req), 32'd1);
    pulse_flag[0] = 1'b1; pulse_flag[1] = 1'b0; pulse_flag[2] = 1'b1;
    pulse_flag[3] = 1'b0; pulse_flag[4] = 1'b1;
    pulse_cnt[0] = 3'd1; pulse_cnt[1] = 3'd2; pulse_cnt[2] = 3'd3;
    pulse_cnt[3] = 3'd4; pulse_cnt[4] = 3'd4;
    pulse_ovf[0] = 1'b0; pulse_ovf[1] = 1'b0; pulse_ovf[2] = 1'b0;
    pulse_ovf[3] = 1'b0; pulse_ovf[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      prod_in = 1'b1; change_in = pulse_flag[i];
      step();
      check("t3_q_count", 32'(q_count), 32'(pulse_cnt[i]));
      check("t3_overflow", 32'(overflow), 32'(pulse_ovf[i]));
      $display("pulse %0d q_count=%0d overflow=%0d", i, q_count, overflow);
    end
    prod_in = 1'b0; change_in = 1'b0;
    step();
    check("t3_ovf_clear", 32'(overflow), 32'd0);
    check("t3_q_hold", 32'(q_count), 32'd4);
    disp_done = 1'b1;
    step();
    disp_done = 1'b0;
    check("t3_a_done", 32'(disp_req), 32'd0);
    check("t3_a_no_hop", 32'(hop_req), 32'd0);

    // push/pop collision on a full queue
    prod_in = 1'b1; change_in = 1'b1;
    step();
    prod_in = 1'b0; change_in = 1'b0;
    check("t4_q_count", 32'(q_count), 32'd4);
    check("t4_overflow", 32'(overflow), 32'd0);
    $display("collision q_count=%0d overflow=%0d", q_count, overflow);

    // FIFO order: 1,0,1,0 then the collision entry 1
    serve(1'b1, 3'd3);
    serve(1'b0, 3'd2);
    serve(1'b1, 3'd1);
    serve(1'b0, 3'd0);
    serve(1'b1, 3'd0);
    check("t4_end_busy", 32'(busy), 32'd0);
    check("t4_end_disp_req", 32'(disp_req), 32'd0);

    // timeout: G (no change) faults, H (change) waits in the queue
    prod_in = 1'b1; change_in = 1'b0;
    step();
    prod_in = 1'b1; change_in = 1'b1;
    step();
    prod_in = 1'b0; change_in = 1'b0;
    check("t5_disp_req", 32'(disp_req), 32'd1);
    check("t5_q_count", 32'(q_count), 32'd1);
    for (int i = 1; i <= 15; i++) begin
      step();
      check("t5_wait_disp_req", 32'(disp_req), 32'd1);
      check("t5_wait_fault", 32'(fault), 32'd0);
    end
    step();
    check("t5_fault", 32'(fault), 32'd1);
    check("t5_fault_disp_req", 32'(disp_req), 32'd0);
    check("t5_fault_hop_req", 32'(hop_req), 32'd0);
    check("t5_fault_busy", 32'(busy), 32'd1);
    $display("timeout fault=%0d q_count=%0d", fault, q_count);
    prod_in = 1'b1; change_in = 1'b0;
    step();
    prod_in = 1'b0;
    check("t5_fault_enq", 32'(q_count), 32'd2);
    step();
    check("t5_fault_sticky", 32'(fault), 32'd1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("t5_clr_fault", 32'(fault), 32'd0);
    check("t5_clr_disp_req", 32'(disp_req), 32'd0);
    step();
    check("t5_next_disp_req", 32'(disp_req), 32'd1);
    check("t5_next_q_count", 32'(q_count), 32'd1);

    // done on the 16th cycle of disp_req wins over the timeout
    for (int i = 1; i <= 15; i++) begin
      step();
    end
    check("t6_cycle16_disp_req", 32'(disp_req), 32'd1);
    disp_done = 1'b1;
    step();
    disp_done = 1'b0;
    check("t6_hop_req", 32'(hop_req), 32'd1);
    check("t6_fault", 32'(fault), 32'd0);
    check("t6_q_count", 32'(q_count), 32'd1);
    $display("late done hop_req=%0d fault=%0d", hop_req, fault);

    // reset mid-HOP
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t7_hop_req", 32'(hop_req), 32'd0);
    check("t7_q_count", 32'(q_count), 32'd0);
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_fault", 32'(fault), 32'd0);
    check("t7_disp_req", 32'(disp_req), 32'd0);
    $display("reset mid-hop busy=%0d q_count=%0d", busy, q_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_dispense_ctrl.md
VEND_DISPENSE_CTRL -- requirements
Module: vend_dispense_ctrl

Interface
REQ-001 Parameter DEPTH, default 4: order-queue depth in entries; fixed at 4 for this release.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles to wait for a done handshake.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 prod_in  input  1  one-cycle vend order from the coin FSM.
REQ-006 change_in  input  1  one-cycle order qualifier: return Rs.1 change; valid only with prod_in.
REQ-007 disp_req  output  1  product dispenser request.
REQ-008 disp_done  input  1  dispenser completion pulse.
REQ-009 hop_req  output  1  change hopper request, for one Rs.1 coin.
REQ-010 hop_done  input  1  hopper completion pulse.
REQ-011 fault_clr  input  1  clears a sticky fault.
REQ-012 busy  output  1  state != IDLE or q_count != 0.
REQ-013 fault  output  1  sticky handshake timeout indication.
REQ-014 overflow  output  1  one-cycle pulse when an order is dropped.
REQ-015 q_count  output  3  number of queued orders, 0..4.

Function
REQ-016 The queue SHALL be a FIFO of 1-bit entries, each holding the change flag, with a registered occupancy count.
REQ-017 An edge with prod_in=1 SHALL enqueue change_in, unless the queue is full and no pop occurs on the same edge.
REQ-018 An order dropped because the queue is full SHALL raise overflow for exactly the next cycle; queue contents SHALL remain unchanged.
REQ-019 A simultaneous push and pop SHALL both take effect: q_count unchanged, no overflow, FIFO order kept, including when full.
REQ-020 change_in=1 with prod_in=0 SHALL be ignored.
REQ-021 The FSM states SHALL be IDLE, DISP, HOP and FAULT.
REQ-022 In IDLE with q_count>0, the FSM SHALL pop the head entry, latch its change flag, clear the timer and go to DISP.
REQ-023 disp_req SHALL equal (state==DISP); hop_req SHALL equal (state==HOP); both are registered-state decodes.
REQ-024 Latency: prod_in sampled on edge E0 with the queue empty and the FSM in IDLE SHALL give disp_req=1 after edge E1.
REQ-025 In DISP, disp_done=1 SHALL move the FSM to HOP if the latched flag is 1, else to IDLE; the timer SHALL be cleared.
REQ-026 In HOP, hop_done=1 SHALL move the FSM to IDLE.
REQ-027 disp_done outside DISP and hop_done outside HOP SHALL be ignored.
REQ-028 The timer SHALL increment each cycle in DISP or HOP; at value TIMEOUT-1 with no done, the FSM SHALL go to FAULT on that edge.
REQ-029 A done pulse on the same cycle as the timeout SHALL win: normal transition, no fault.
REQ-030 In FAULT, fault=1 and both requests are 0; the in-flight order is discarded; enqueueing continues.
REQ-031 fault_clr=1 in FAULT SHALL return the FSM to IDLE; fault_clr in any other state SHALL be ignored.
REQ-032 fault SHALL equal (state==FAULT).

Reset
REQ-033 rst=1 SHALL set state=IDLE, q_count=0, empty the FIFO pointers, clear the timer and the latched flag, and drive overflow=0.
REQ-034 Reset SHALL take priority over all inputs, including mid-DISP or mid-HOP; the in-flight order is abandoned and outputs are 0 from the next cycle.

Verification
REQ-035 Single order, no change: prod_in=1, change_in=0 at E0; disp_done 3 cycles after disp_req rises -> disp_req high E1..done, then IDLE, hop_req never high, busy=0.
REQ-036 Order with change: prod_in=1, change_in=1; disp_done, then hop_done after 2 cycles -> hop_req high the cycle after disp_done until hop_done, then IDLE.
REQ-037 Overflow: FSM held in DISP, 5 prod_in pulses -> q_count saturates at 4, exactly one overflow pulse, then 4 orders served in FIFO order, checked by change flags 1,0,1,0.
REQ-038 Timeout: no disp_done for 16 cycles -> FAULT after 16 cycles of disp_req, fault=1; fault_clr -> IDLE and the next queued order is served; done on cycle 16 -> no fault.
REQ-039 Push/pop collision: queue full and FSM popping on the same edge as prod_in -> q_count stays 4, overflow=0.
REQ-040 Reset mid-HOP: rst during hop_req=1 -> next cycle hop_req=0, q_count=0, busy=0, fault=0.
